// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared definitions for clock-divider side monitors.
//   state_t      - monitor FSM state encoding
//   CNT_W_DEF    - default width of the high/low/period counters
//   MCNT_W       - width of the consecutive-match counter (LOCK_NUM <= 15)
//   MIN_EXP_DIV  - smallest expected divide ratio that can ever match
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HI   = 2'd2,
    MEAS_LO   = 2'd3
  } state_t;

  localparam int CNT_W_DEF   = 8;
  localparam int MCNT_W      = 4;
  localparam int MIN_EXP_DIV = 2;

endpackage

// File: rtl/clk_div_mon_if.sv
// clk_div_mon_if: signal bundle between a divider monitor and its user.
//   master: drives en, clk_div_in, exp_div, err_clr; observes results.
//   slave : the monitor; drives hi_len, lo_len, period, meas_valid,
//           locked, stuck, err and the debug state.
// meas_valid and stuck are one-cycle strobes with no back-pressure: the
// consumer must take hi_len/lo_len/period in the cycle meas_valid is high
// (they also hold until the next measurement).
interface clk_div_mon_if #(
  parameter int CNT_W = clk_div_pkg::CNT_W_DEF
);
  import clk_div_pkg::*;

  logic             en;
  logic             clk_div_in;
  logic [CNT_W-1:0] exp_div;
  logic             err_clr;
  logic [CNT_W-1:0] hi_len;
  logic [CNT_W-1:0] lo_len;
  logic [CNT_W-1:0] period;
  logic             meas_valid;
  logic             locked;
  logic             stuck;
  logic             err;
  state_t           dbg_state;

  modport master (
    output en, clk_div_in, exp_div, err_clr,
    input  hi_len, lo_len, period, meas_valid, locked, stuck, err, dbg_state
  );

  modport slave (
    input  en, clk_div_in, exp_div, err_clr,
    output hi_len, lo_len, period, meas_valid, locked, stuck, err, dbg_state
  );

endinterface

// File: rtl/clk_edge_det.sv
// clk_edge_det: registers a clk-synchronous level and reports its edges.
//   clk, rstn : source clock, synchronous active-low reset
//   d         : level to watch (already synchronous to clk)
//   rise/fall : combinational single-cycle edge indications
module clk_edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rstn) prev_q <= 1'b0;
    else       prev_q <= d;
  end

  assign rise = d & ~prev_q;
  assign fall = ~d & prev_q;

endmodule

// File: rtl/clk_div_mon.sv
// clk_div_mon: measures high time, low time and period of a divided clock
// in source-clock cycles, checks each period against exp_div, reports
// lock after LOCK_NUM consecutive matches, and flags mismatch / stuck.
//   clk, rstn : source clock, synchronous active-low reset
//   bus       : clk_div_mon_if slave modport (controls in, results out)
module clk_div_mon
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int LOCK_NUM = 2
) (
  input  logic         clk,
  input  logic         rstn,
  clk_div_mon_if.slave bus
);

  // Stuck fires on the 255th edge-less cycle of a level (for CNT_W=8),
  // i.e. when the counter would reach all-ones.
  localparam logic [CNT_W-1:0]  STUCK_AT = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0]  EXP_MIN  = CNT_W'(MIN_EXP_DIV);
  localparam logic [MCNT_W-1:0] LOCK_CNT = MCNT_W'(LOCK_NUM);

  logic rise, fall;

  clk_edge_det u_edge (
    .clk  (clk),
    .rstn (rstn),
    .d    (bus.clk_div_in),
    .rise (rise),
    .fall (fall)
  );

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d, lcnt_q, lcnt_d, hlat_q, hlat_d;
  logic [CNT_W-1:0]  hi_len_q, hi_len_d, lo_len_q, lo_len_d, period_q, period_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic              meas_valid_q, meas_valid_d, locked_q, locked_d;
  logic              stuck_q, stuck_d, err_q, err_d, err_set;

  // Match rule: full period equals exp_div (no sum overflow) and the high
  // time is either half of exp_div rounded down or rounded up.
  logic [CNT_W:0]   sum_w, exp_p1;
  logic [CNT_W-1:0] half_dn, half_up;
  logic             period_match;

  assign sum_w   = {1'b0, hlat_q} + {1'b0, lcnt_q};
  assign exp_p1  = {1'b0, bus.exp_div} + (CNT_W+1)'(1);
  assign half_dn = bus.exp_div >> 1;
  assign half_up = exp_p1[CNT_W:1];
  assign period_match = (bus.exp_div >= EXP_MIN) && !sum_w[CNT_W] &&
                        (sum_w[CNT_W-1:0] == bus.exp_div) &&
                        ((hlat_q == half_dn) || (hlat_q == half_up));

  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    lcnt_d       = lcnt_q;
    hlat_d       = hlat_q;
    mcnt_d       = mcnt_q;
    hi_len_d     = hi_len_q;
    lo_len_d     = lo_len_q;
    period_d     = period_q;
    meas_valid_d = 1'b0;
    stuck_d      = 1'b0;
    locked_d     = locked_q;
    err_set      = 1'b0;

    if (!bus.en) begin
      state_d  = IDLE;
      hcnt_d   = '0;
      lcnt_d   = '0;
      hlat_d   = '0;
      mcnt_d   = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_RISE;
        WAIT_RISE: begin
          if (rise) begin
            state_d = MEAS_HI;
            hcnt_d  = CNT_W'(1);
          end
        end
        MEAS_HI: begin
          if (fall) begin
            hlat_d  = hcnt_q;
            lcnt_d  = CNT_W'(1);
            state_d = MEAS_LO;
          end else if (hcnt_q == STUCK_AT) begin
            stuck_d  = 1'b1;
            err_set  = 1'b1;
            locked_d = 1'b0;
            mcnt_d   = '0;
            hcnt_d   = '0;
            state_d  = WAIT_RISE;
          end else begin
            hcnt_d = hcnt_q + CNT_W'(1);
          end
        end
        MEAS_LO: begin
          if (rise) begin
            // Rise closes the period and also opens the next one.
            hi_len_d     = hlat_q;
            lo_len_d     = lcnt_q;
            period_d     = sum_w[CNT_W-1:0];
            meas_valid_d = 1'b1;
            hcnt_d       = CNT_W'(1);
            state_d      = MEAS_HI;
            if (period_match) begin
              mcnt_d   = (mcnt_q == LOCK_CNT) ? mcnt_q : mcnt_q + MCNT_W'(1);
              locked_d = (mcnt_d == LOCK_CNT);
            end else begin
              mcnt_d   = '0;
              locked_d = 1'b0;
              err_set  = 1'b1;
            end
          end else if (lcnt_q == STUCK_AT) begin
            stuck_d  = 1'b1;
            err_set  = 1'b1;
            locked_d = 1'b0;
            mcnt_d   = '0;
            lcnt_d   = '0;
            state_d  = WAIT_RISE;
          end else begin
            lcnt_d = lcnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A new error in the same cycle as err_clr wins.
    err_d = bus.en & (err_set | (err_q & ~bus.err_clr));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      hcnt_q       <= '0;
      lcnt_q       <= '0;
      hlat_q       <= '0;
      mcnt_q       <= '0;
      hi_len_q     <= '0;
      lo_len_q     <= '0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      stuck_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      lcnt_q       <= lcnt_d;
      hlat_q       <= hlat_d;
      mcnt_q       <= mcnt_d;
      hi_len_q     <= hi_len_d;
      lo_len_q     <= lo_len_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      stuck_q      <= stuck_d;
      err_q        <= err_d;
    end
  end

  assign bus.hi_len     = hi_len_q;
  assign bus.lo_len     = lo_len_q;
  assign bus.period     = period_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.locked     = locked_q;
  assign bus.stuck      = stuck_q;
  assign bus.err        = err_q;
  assign bus.dbg_state  = state_q;

endmodule
